// File: rtl/bellman_ford_engine.sv
// Bellman-Ford single-source shortest-path engine over a preloaded edge list.
// Define BF_EARLY_EXIT_EN to leave RELAX after the first pass that makes no update.

module bf_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384,
    parameter int AW     = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] Register [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (we)
            Register[waddr] <= wdata;
    end

    // Read-before-write: rdata shows the contents as they were one cycle earlier.
    always_ff @(posedge clock) begin
        if (reset)
            rdata <= '0;
        else
            rdata <= Register[raddr];
    end
endmodule

module bellman_ford_engine #(
    parameter int                DATA_W    = 16,
    parameter int                MAX_NODES = 256,
    parameter int                MEM_DEPTH = 16384,
    parameter logic [DATA_W-1:0] INF       = 16'h7FFF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(MEM_DEPTH)-1:0] output_address,
    output logic [DATA_W-1:0]            final_output,
    output logic                         finish,
    output logic                         n_exist,
    output logic                         simulation_finish
);
    localparam int EA_W = $clog2(MEM_DEPTH);
    localparam int WDEPTH = 2 * MAX_NODES + 1;
    localparam int WA_W = $clog2(WDEPTH);
    localparam logic [WA_W-1:0] PRED_BASE = WA_W'(MAX_NODES);

    typedef enum logic [2:0] {IDLE, HDR, INIT, RELAX, CHECK, TRACE, DONE} state_t;
    state_t state;

    logic [2:0]        step;
    logic [DATA_W-1:0] n_nodes, n_edges, src, dst;
    logic [DATA_W-1:0] node, pass, edge_idx, eu, ew, du, cur, tcount;
    logic [WA_W-1:0]   ev;
    logic [EA_W-1:0]   edge_base, oaddr;
    logic              updated;

    logic [EA_W-1:0]   edge_raddr;
    logic [DATA_W-1:0] edge_rdata;
    logic              work_we;
    logic [WA_W-1:0]   work_waddr, work_raddr;
    logic [DATA_W-1:0] work_wdata, work_rdata;
    logic              out_we;
    logic [EA_W-1:0]   out_waddr;
    logic [DATA_W-1:0] out_wdata;

    bf_mem #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH), .AW(EA_W)) uut8 (
        .clock(clock), .reset(reset), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(edge_raddr), .rdata(edge_rdata)
    );

    bf_mem #(.DATA_W(DATA_W), .DEPTH(WDEPTH), .AW(WA_W)) uut2 (
        .clock(clock), .reset(reset), .we(work_we), .waddr(work_waddr), .wdata(work_wdata),
        .raddr(work_raddr), .rdata(work_rdata)
    );

    bf_mem #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH), .AW(EA_W)) uut9 (
        .clock(clock), .reset(reset), .we(out_we), .waddr(out_waddr), .wdata(out_wdata),
        .raddr(output_address), .rdata(final_output)
    );

    // Step 5 of an edge: du is dist[u], work_rdata is dist[v].
    logic signed [DATA_W:0] sum;
    logic                   relax_hit, edge_done, last_edge, quiet_pass;
    logic [DATA_W-1:0]      sat_sum;

    assign sum       = $signed({du[DATA_W-1], du}) + $signed({ew[DATA_W-1], ew});
    assign relax_hit = (du != INF) && (sum < $signed({work_rdata[DATA_W-1], work_rdata}));
    assign sat_sum   = (sum < -$signed((DATA_W+1)'(1) <<< (DATA_W-1)))
                       ? {1'b1, {(DATA_W-1){1'b0}}} : sum[DATA_W-1:0];
    assign last_edge = (edge_idx == n_edges - 1'b1);
    assign edge_done = (state == RELAX) ? ((step == 3'd5 && !relax_hit) || step == 3'd6)
                                        : (state == CHECK && step == 3'd5 && !relax_hit);
`ifdef BF_EARLY_EXIT_EN
    assign quiet_pass = !(updated || step == 3'd6);
`else
    assign quiet_pass = 1'b0;
`endif

    always_comb begin
        edge_raddr = edge_base;
        work_raddr = '0;
        work_we    = 1'b0;
        work_waddr = '0;
        work_wdata = '0;
        out_we     = 1'b0;
        out_waddr  = oaddr;
        out_wdata  = '0;
        case (state)
            IDLE: edge_raddr = '0;
            HDR:  edge_raddr = EA_W'(step) + EA_W'(1);
            INIT: begin
                work_we = 1'b1;
                case (step)
                    3'd0:    begin work_waddr = node[WA_W-1:0]; work_wdata = INF; end
                    3'd1:    work_waddr = PRED_BASE + node[WA_W-1:0];
                    default: work_waddr = src[WA_W-1:0];
                endcase
            end
            RELAX, CHECK: begin
                if (step == 3'd1)      edge_raddr = edge_base + EA_W'(1);
                else if (step == 3'd2) edge_raddr = edge_base + EA_W'(2);
                if (step == 3'd3)      work_raddr = eu[WA_W-1:0];
                else if (step == 3'd4) work_raddr = ev;
                if (state == RELAX && step == 3'd5 && relax_hit) begin
                    work_we = 1'b1; work_waddr = ev; work_wdata = sat_sum;
                end
                if (state == RELAX && step == 3'd6) begin
                    work_we = 1'b1; work_waddr = PRED_BASE + ev; work_wdata = eu;
                end
            end
            TRACE: begin
                case (step)
                    3'd0: work_raddr = dst[WA_W-1:0];
                    3'd1: if (work_rdata == INF) begin
                        out_we = 1'b1; out_waddr = '0; out_wdata = '1;
                    end
                    3'd2: begin
                        work_raddr = PRED_BASE + cur[WA_W-1:0];
                        if (cur != '0) begin out_we = 1'b1; out_wdata = cur; end
                    end
                    3'd4: out_we = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE; step <= '0;
            n_nodes <= '0; n_edges <= '0; src <= '0; dst <= '0;
            node <= '0; pass <= '0; edge_idx <= '0; eu <= '0; ev <= '0; ew <= '0; du <= '0;
            cur <= '0; tcount <= '0; edge_base <= '0; oaddr <= '0; updated <= 1'b0;
            finish <= 1'b0; n_exist <= 1'b0; simulation_finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin state <= HDR; step <= '0; end
                HDR: begin
                    step <= step + 3'd1;
                    case (step)
                        3'd0: n_nodes <= edge_rdata;
                        3'd1: n_edges <= edge_rdata;
                        3'd2: src <= edge_rdata;
                        default: begin
                            dst   <= edge_rdata;
                            node  <= DATA_W'(1);
                            step  <= (n_nodes == '0) ? 3'd2 : 3'd0;
                            state <= INIT;
                        end
                    endcase
                end
                INIT: begin
                    case (step)
                        3'd0: step <= 3'd1;
                        3'd1: begin
                            node <= node + 1'b1;
                            step <= (node == n_nodes) ? 3'd2 : 3'd0;
                        end
                        default: begin
                            edge_idx <= '0; edge_base <= EA_W'(4); pass <= DATA_W'(1);
                            updated <= 1'b0; step <= '0;
                            state <= (n_nodes <= DATA_W'(1) || n_edges == '0) ? CHECK : RELAX;
                        end
                    endcase
                end
                RELAX, CHECK: begin
                    case (step)
                        3'd0: step <= 3'd1;
                        3'd1: begin eu <= edge_rdata; step <= 3'd2; end
                        3'd2: begin ev <= edge_rdata[WA_W-1:0]; step <= 3'd3; end
                        3'd3: begin ew <= edge_rdata; step <= 3'd4; end
                        3'd4: begin du <= work_rdata; step <= 3'd5; end
                        3'd5: if (relax_hit) begin
                            if (state == CHECK) begin
                                n_exist <= 1'b1; finish <= 1'b1; simulation_finish <= 1'b1;
                                state <= DONE;
                            end else
                                step <= 3'd6;
                        end
                        3'd6: updated <= 1'b1;
                        default: ;
                    endcase
                    // An empty edge list reaches CHECK with nothing to scan.
                    if (state == CHECK && n_edges == '0) begin
                        finish <= 1'b1; state <= TRACE; step <= '0;
                    end else if (edge_done) begin
                        step <= '0;
                        if (!last_edge) begin
                            edge_idx  <= edge_idx + 1'b1;
                            edge_base <= edge_base + EA_W'(3);
                        end else begin
                            edge_idx <= '0; edge_base <= EA_W'(4); updated <= 1'b0;
                            if (state == CHECK) begin
                                finish <= 1'b1; state <= TRACE;
                            end else if (pass >= n_nodes - 1'b1 || quiet_pass)
                                state <= CHECK;
                            else
                                pass <= pass + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    case (step)
                        3'd0: step <= 3'd1;
                        3'd1: if (work_rdata == INF) begin
                            oaddr <= EA_W'(1); step <= 3'd4;
                        end else begin
                            cur <= dst; tcount <= '0; oaddr <= '0; step <= 3'd2;
                        end
                        3'd2: if (cur == '0)
                            step <= 3'd4;
                        else begin
                            oaddr  <= oaddr + 1'b1;
                            tcount <= tcount + 1'b1;
                            step   <= (cur == src || tcount + 1'b1 >= n_nodes) ? 3'd4 : 3'd3;
                        end
                        3'd3: begin cur <= work_rdata; step <= 3'd2; end
                        default: begin simulation_finish <= 1'b1; state <= DONE; end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bellman_ford_engine.sv
// Scoreboard bench for bellman_ford_engine: graphs are loaded into the edge memory
// while reset is held, expected output words are queued and compared on readback.
module tb_bellman_ford_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] output_address = '0;
    logic [15:0] final_output;
    logic        finish, n_exist, simulation_finish;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    int g_u[4], g_v[4], g_w[4];

    bellman_ford_engine dut (
        .clock(clock), .reset(reset), .output_address(output_address),
        .final_output(final_output), .finish(finish), .n_exist(n_exist),
        .simulation_finish(simulation_finish)
    );

    always #5 clock = ~clock;

    task automatic load_graph(input int n, input int e, input int s, input int d);
        dut.uut8.Register[0] = 16'(n);
        dut.uut8.Register[1] = 16'(e);
        dut.uut8.Register[2] = 16'(s);
        dut.uut8.Register[3] = 16'(d);
        for (int k = 0; k < e; k++) begin
            dut.uut8.Register[14'(4 + 3 * k)] = 16'(g_u[k]);
            dut.uut8.Register[14'(5 + 3 * k)] = 16'(g_v[k]);
            dut.uut8.Register[14'(6 + 3 * k)] = 16'(g_w[k]);
        end
    endtask

    task automatic set_basic();
        g_u = '{1, 2, 1, 0}; g_v = '{2, 3, 3, 0}; g_w = '{4, 3, 10, 0};
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clock); #1;
            if (simulation_finish) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_graph(input int n, input int e, input int s, input int d, output bit ok);
        @(negedge clock); reset = 1'b1;
        load_graph(n, e, s, d);
        @(negedge clock); reset = 1'b0;
        wait_done(ok);
    endtask

    task automatic rd(input logic [13:0] a, output logic [15:0] data);
        @(negedge clock); output_address = a;
        @(posedge clock); #1; data = final_output;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if ({finish, n_exist, simulation_finish} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {finish, n_exist, simulation_finish});
        end
        vectors++;
        if (final_output !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_final_output: got %h expected 0000", final_output);
        end
    endtask

    task automatic test_basic_path();
        bit ok; logic [15:0] got, e;
        set_basic();
        run_graph(3, 3, 1, 3, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_done: simulation_finish 0 after timeout, expected 1"); end
        vectors++;
        if ({finish, n_exist} !== 2'b10) begin
            miscompares++; $display("FAIL basic_flags: finish,n_exist got %b expected 10", {finish, n_exist});
        end
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            rd(14'(i), got); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL basic_out[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_neg_cycle();
        bit ok; logic [15:0] got, e;
        g_u = '{1, 2, 0, 0}; g_v = '{2, 1, 0, 0}; g_w = '{1, -2, 0, 0};
        run_graph(2, 2, 1, 2, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL neg_done: simulation_finish 0 after timeout, expected 1"); end
        vectors++;
        if ({finish, n_exist} !== 2'b11) begin
            miscompares++; $display("FAIL neg_flags: finish,n_exist got %b expected 11", {finish, n_exist});
        end
        // Output memory must still hold the previous run's path.
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0002);
        for (int i = 0; i < 2; i++) begin
            rd(14'(i), got); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL neg_out_untouched[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_unreachable();
        bit ok; logic [15:0] got, e;
        g_u = '{1, 0, 0, 0}; g_v = '{2, 0, 0, 0}; g_w = '{5, 0, 0, 0};
        run_graph(3, 1, 1, 3, ok);
        vectors++;
        if (!ok || n_exist !== 1'b0) begin
            miscompares++; $display("FAIL unreach_flags: done=%b n_exist=%b expected 1 0", ok, n_exist);
        end
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
        for (int i = 0; i < 2; i++) begin
            rd(14'(i), got); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL unreach_out[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_src_eq_dst();
        bit ok; logic [15:0] got, e;
        set_basic();
        run_graph(3, 3, 2, 2, ok);
        vectors++;
        if (!ok || n_exist !== 1'b0) begin
            miscompares++; $display("FAIL srcdst_flags: done=%b n_exist=%b expected 1 0", ok, n_exist);
        end
        exp_q.push_back(16'h0002); exp_q.push_back(16'h0000);
        for (int i = 0; i < 2; i++) begin
            rd(14'(i), got); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL srcdst_out[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [15:0] got, e;
        set_basic();
        @(negedge clock); reset = 1'b1;
        load_graph(3, 3, 1, 3);
        @(negedge clock); reset = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if ({finish, n_exist, simulation_finish} !== 3'b000 || final_output !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_clear: flags %b out %h expected 000 0000",
                     {finish, n_exist, simulation_finish}, final_output);
        end
        @(negedge clock); reset = 1'b0;
        wait_done(ok);
        vectors++;
        if (!ok || {finish, n_exist} !== 2'b10) begin
            miscompares++; $display("FAIL midreset_rerun: done=%b finish,n_exist=%b expected 1 10", ok, {finish, n_exist});
        end
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        for (int i = 0; i < 4; i++) begin
            rd(14'(i), got); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL midreset_out[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_read_latency();
        logic [15:0] e;
        @(negedge clock); output_address = 14'd0;
        exp_q.push_back(16'h0003);
        @(posedge clock); #1;
        e = exp_q.pop_front(); vectors++;
        if (final_output !== e) begin miscompares++; $display("FAIL latency_addr0: got %h expected %h", final_output, e); end
        @(negedge clock); output_address = 14'd1;
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0002);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (final_output !== e) begin miscompares++; $display("FAIL latency_before_edge: got %h expected %h", final_output, e); end
        @(posedge clock); #1;
        e = exp_q.pop_front(); vectors++;
        if (final_output !== e) begin miscompares++; $display("FAIL latency_after_edge: got %h expected %h", final_output, e); end
    endtask

    initial begin
        test_reset();
        test_basic_path();
        test_neg_cycle();
        test_unreachable();
        test_src_eq_dst();
        test_reset_mid();
        test_read_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
